// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the in-order pipeline, built on a shift-register scoreboard.
// Optional macro HAZARD_WB_BYPASS_EN lets the write-back slot forward through the retired-result latch.
module hazard_fwd_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_RD     = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         id_valid,
  input  logic [NUM_RD*REG_ADDR_W-1:0] id_rd_reg,
  input  logic [NUM_RD-1:0]            id_rd_use,
  input  logic                         id_early,
  input  logic                         id_wr_en,
  input  logic [REG_ADDR_W-1:0]        id_wr_reg,
  input  logic                         id_is_load,
  input  logic                         flush_id,
  output logic                         stall,
  output logic [NUM_RD*SEL_W-1:0]      id_fwd_sel,
  output logic [NUM_RD*SEL_W-1:0]      ex_fwd_sel,
  output logic [15:0]                  stall_count
);

  localparam int LAT_W = $clog2(LOAD_LAT + 1);
`ifdef HAZARD_WB_BYPASS_EN
  localparam int MATCH_MAX = PIPE_DEPTH;
`else
  localparam int MATCH_MAX = PIPE_DEPTH - 1;
`endif

  logic [PIPE_DEPTH:1]   slot_vld_q, slot_vld_d;
  logic [REG_ADDR_W-1:0] slot_reg_q [1:PIPE_DEPTH];
  logic [REG_ADDR_W-1:0] slot_reg_d [1:PIPE_DEPTH];
  logic [LAT_W-1:0]      slot_lat_q [1:PIPE_DEPTH];
  logic [LAT_W-1:0]      slot_lat_d [1:PIPE_DEPTH];
  logic [NUM_RD*SEL_W-1:0] ex_fwd_sel_q, ex_fwd_sel_d;
  logic [15:0]             stall_count_q, stall_count_d;

  logic                    stall_hit;
  logic                    issue;
  logic [NUM_RD*SEL_W-1:0] ex_src;
  logic [NUM_RD*SEL_W-1:0] id_src;

  // Youngest matching producer per operand decides both the stall and the source.
  always_comb begin : match_blk
    logic [REG_ADDR_W-1:0] rs;
    int k_hit;
    int lat_hit;
    stall_hit = 1'b0;
    ex_src    = '0;
    id_src    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rs      = id_rd_reg[i*REG_ADDR_W +: REG_ADDR_W];
      k_hit   = 0;
      lat_hit = 0;
      for (int k = MATCH_MAX; k >= 1; k--) begin
        if (id_rd_use[i] && (rs != '0) && slot_vld_q[k] && (slot_reg_q[k] == rs)) begin
          k_hit   = k;
          lat_hit = int'(slot_lat_q[k]);
        end
      end
      if (k_hit != 0) begin
        ex_src[i*SEL_W +: SEL_W] = SEL_W'(k_hit);
        id_src[i*SEL_W +: SEL_W] = SEL_W'(k_hit - 1);
        if (!id_early && (k_hit < lat_hit))
          stall_hit = 1'b1;
        if (id_early && ((k_hit - 1) < lat_hit))
          stall_hit = 1'b1;
      end
    end
  end

  assign stall      = id_valid & ~flush_id & stall_hit;
  assign issue      = id_valid & ~flush_id & ~stall;
  assign id_fwd_sel = (id_valid & id_early & ~stall) ? id_src : '0;
  assign ex_fwd_sel = ex_fwd_sel_q;
  assign stall_count = stall_count_q;

  always_comb begin
    slot_vld_d[1] = issue & id_wr_en & (id_wr_reg != '0);
    slot_reg_d[1] = id_wr_reg;
    slot_lat_d[1] = id_is_load ? LAT_W'(LOAD_LAT) : LAT_W'(1);
    for (int k = 2; k <= PIPE_DEPTH; k++) begin
      slot_vld_d[k] = slot_vld_q[k-1];
      slot_reg_d[k] = slot_reg_q[k-1];
      slot_lat_d[k] = slot_lat_q[k-1];
    end
    ex_fwd_sel_d  = issue ? ex_src : '0;
    stall_count_d = (stall && (stall_count_q != 16'hFFFF)) ? stall_count_q + 16'd1 : stall_count_q;
  end

  // Stage boundary: scoreboard advance and EX select capture.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      slot_vld_q    <= '0;
      ex_fwd_sel_q  <= '0;
      stall_count_q <= '0;
    end else begin
      slot_vld_q    <= slot_vld_d;
      ex_fwd_sel_q  <= ex_fwd_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      slot_reg_q[k] <= slot_reg_d[k];
      slot_lat_q[k] <= slot_lat_d[k];
    end
  end

`ifndef HAZARD_WB_BYPASS_EN
  // Write-back slot only ages out here; the write-through register file covers it.
  logic unused_wb_slot;
  assign unused_wb_slot = ^{slot_vld_q[PIPE_DEPTH], slot_reg_q[PIPE_DEPTH], slot_lat_q[PIPE_DEPTH]};
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus random traffic against an issue-history model.
module tb_hazard_fwd_unit;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_RD     = 2;
  localparam int PIPE_DEPTH = 3;
  localparam int LOAD_LAT   = 2;
  localparam int SEL_W      = $clog2(PIPE_DEPTH + 1);
`ifdef HAZARD_WB_BYPASS_EN
  localparam int KMAX = PIPE_DEPTH;
  localparam int BYP_SEL = 3;
  localparam int EARLY_LD_SEL = 2;
`else
  localparam int KMAX = PIPE_DEPTH - 1;
  localparam int BYP_SEL = 0;
  localparam int EARLY_LD_SEL = 0;
`endif

  logic                         Clk = 1'b0;
  logic                         Rst_n = 1'b0;
  logic                         id_valid = 1'b0;
  logic [NUM_RD*REG_ADDR_W-1:0] id_rd_reg = '0;
  logic [NUM_RD-1:0]            id_rd_use = '0;
  logic                         id_early = 1'b0;
  logic                         id_wr_en = 1'b0;
  logic [REG_ADDR_W-1:0]        id_wr_reg = '0;
  logic                         id_is_load = 1'b0;
  logic                         flush_id = 1'b0;
  logic                         stall;
  logic [NUM_RD*SEL_W-1:0]      id_fwd_sel;
  logic [NUM_RD*SEL_W-1:0]      ex_fwd_sel;
  logic [15:0]                  stall_count;

  hazard_fwd_unit #(
    .REG_ADDR_W(REG_ADDR_W), .NUM_RD(NUM_RD), .PIPE_DEPTH(PIPE_DEPTH),
    .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_rd_reg(id_rd_reg),
    .id_rd_use(id_rd_use), .id_early(id_early), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush_id(flush_id),
    .stall(stall), .id_fwd_sel(id_fwd_sel), .ex_fwd_sel(ex_fwd_sel),
    .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: a list of issued writers stamped with their issue cycle.
  typedef struct {int r; int lat; int cyc;} wr_t;
  wr_t hist[$];
  int  cyc = 0;
  int  m_cnt = 0;
  int  m_ex[NUM_RD];
  int  e_id[NUM_RD];
  int  e_src[NUM_RD];
  logic e_stall;
  logic started = 1'b0;

  logic cur_v, cur_early, cur_we, cur_ld, cur_fl, cur_rstn;
  logic [1:0] cur_use;
  int cur_rs[NUM_RD];
  int cur_wr;

  logic obs_stall;
  int   obs_id[NUM_RD];
  int   obs_ex[NUM_RD];
  int   obs_cnt;

  task automatic model_eval();
    logic any;
    any = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      int best, blat;
      best = 0; blat = 0;
      e_id[i] = 0; e_src[i] = 0;
      if (cur_use[i] && cur_rs[i] != 0) begin
        foreach (hist[j]) begin
          int age;
          age = cyc - hist[j].cyc;
          if (hist[j].r == cur_rs[i] && age >= 1 && age <= KMAX && (best == 0 || age < best)) begin
            best = age;
            blat = hist[j].lat;
          end
        end
      end
      if (best != 0) begin
        e_src[i] = best;
        e_id[i]  = best - 1;
        if (!cur_early && best < blat) any = 1'b1;
        if (cur_early && (best - 1) < blat) any = 1'b1;
      end
    end
    e_stall = cur_v && !cur_fl && any;
    if (!cur_v || !cur_early || e_stall)
      for (int i = 0; i < NUM_RD; i++) e_id[i] = 0;
  endtask

  task automatic model_edge();
    logic iss;
    iss = cur_v && !cur_fl && !e_stall;
    if (!cur_rstn) begin
      hist.delete();
      m_cnt = 0;
      for (int i = 0; i < NUM_RD; i++) m_ex[i] = 0;
    end else begin
      if (e_stall && m_cnt < 65535) m_cnt++;
      for (int i = 0; i < NUM_RD; i++) m_ex[i] = iss ? e_src[i] : 0;
      if (iss && cur_we && cur_wr != 0)
        hist.push_back('{r: cur_wr, lat: (cur_ld ? LOAD_LAT : 1), cyc: cyc});
    end
    cyc++;
    while (hist.size() > 0 && (cyc - hist[0].cyc) > PIPE_DEPTH) void'(hist.pop_front());
  endtask

  task automatic step(input logic v, input int r0, input int r1, input logic [1:0] u,
                      input logic e, input logic we, input int wr, input logic ld,
                      input logic fl, input logic rn);
    cur_v = v; cur_rs[0] = r0; cur_rs[1] = r1; cur_use = u; cur_early = e;
    cur_we = we; cur_wr = wr; cur_ld = ld; cur_fl = fl; cur_rstn = rn;
    id_valid = v; id_rd_reg = {REG_ADDR_W'(r1), REG_ADDR_W'(r0)}; id_rd_use = u;
    id_early = e; id_wr_en = we; id_wr_reg = REG_ADDR_W'(wr); id_is_load = ld;
    flush_id = fl; Rst_n = rn;
    #2;
    model_eval();
    obs_stall = stall;
    obs_cnt   = int'(stall_count);
    for (int i = 0; i < NUM_RD; i++) begin
      obs_id[i] = int'(id_fwd_sel[i*SEL_W +: SEL_W]);
      obs_ex[i] = int'(ex_fwd_sel[i*SEL_W +: SEL_W]);
    end
    if (started) begin
      check_eq("m_stall", {31'd0, stall}, int'(e_stall));
      check_eq("m_id0", 32'(id_fwd_sel[0 +: SEL_W]), e_id[0]);
      check_eq("m_id1", 32'(id_fwd_sel[SEL_W +: SEL_W]), e_id[1]);
      check_eq("m_ex0", 32'(ex_fwd_sel[0 +: SEL_W]), m_ex[0]);
      check_eq("m_ex1", 32'(ex_fwd_sel[SEL_W +: SEL_W]), m_ex[1]);
      check_eq("m_cnt", 32'(stall_count), m_cnt);
    end
    @(posedge Clk);
    #1;
    model_edge();
    started = 1'b1;
  endtask

  task automatic nop();              step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1); endtask
  task automatic rst_cyc();          step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input int wr, input int a, input int b); step(1, a, b, 2'b11, 0, 1, wr, 0, 0, 1); endtask
  task automatic lw(input int wr, input int a);               step(1, a, 0, 2'b01, 0, 1, wr, 1, 0, 1); endtask
  task automatic use2(input int a, input int b);              step(1, a, b, 2'b11, 0, 0, 0, 0, 0, 1); endtask
  task automatic br(input int a, input int b);                step(1, a, b, 2'b11, 1, 0, 0, 0, 0, 1); endtask

  initial begin
    rst_cyc();
    rst_cyc();
    nop();
    check_eq("rst_stall", {31'd0, obs_stall}, 0);
    check_eq("rst_ex0", obs_ex[0], 0);
    check_eq("rst_cnt", obs_cnt, 0);

    alu(3, 1, 2);
    alu(4, 3, 1);
    check_eq("alu_stall", {31'd0, obs_stall}, 0);
    nop();
    check_eq("alu_ex0", obs_ex[0], 1);
    check_eq("alu_ex1", obs_ex[1], 0);

    rst_cyc();
    lw(5, 1);
    alu(6, 5, 5);
    check_eq("lu_stall1", {31'd0, obs_stall}, 1);
    alu(6, 5, 5);
    check_eq("lu_stall2", {31'd0, obs_stall}, 0);
    nop();
    check_eq("lu_ex0", obs_ex[0], 2);
    check_eq("lu_ex1", obs_ex[1], 2);
    check_eq("lu_cnt", obs_cnt, 1);

    rst_cyc();
    alu(7, 1, 2);
    br(7, 0);
    check_eq("br_stall1", {31'd0, obs_stall}, 1);
    br(7, 0);
    check_eq("br_stall2", {31'd0, obs_stall}, 0);
    check_eq("br_id0", obs_id[0], 1);
    check_eq("br_id1", obs_id[1], 0);

    rst_cyc();
    lw(7, 1);
    br(7, 0);
    check_eq("brl_stall1", {31'd0, obs_stall}, 1);
    br(7, 0);
    check_eq("brl_stall2", {31'd0, obs_stall}, 1);
    br(7, 0);
    check_eq("brl_stall3", {31'd0, obs_stall}, 0);
    check_eq("brl_id0", obs_id[0], EARLY_LD_SEL);
    nop();
    check_eq("brl_cnt", obs_cnt, 2);

    rst_cyc();
    alu(0, 1, 2);
    use2(0, 1);
    check_eq("r0_stall", {31'd0, obs_stall}, 0);
    nop();
    check_eq("r0_ex0", obs_ex[0], 0);

    rst_cyc();
    alu(2, 1, 1);
    alu(2, 1, 1);
    use2(2, 0);
    nop();
    check_eq("young_ex0", obs_ex[0], 1);

    rst_cyc();
    lw(5, 1);
    alu(6, 5, 5);
    check_eq("fl_pre", {31'd0, obs_stall}, 1);
    step(1, 5, 5, 2'b11, 0, 1, 6, 0, 1, 1);
    check_eq("fl_stall", {31'd0, obs_stall}, 0);
    nop();
    check_eq("fl_ex0", obs_ex[0], 0);
    check_eq("fl_ex1", obs_ex[1], 0);

    lw(1, 2);
    alu(8, 1, 1);
    alu(9, 1, 1);
    step(1, 9, 9, 2'b11, 1, 0, 0, 0, 0, 0);
    br(9, 8);
    check_eq("mr_stall", {31'd0, obs_stall}, 0);
    check_eq("mr_id0", obs_id[0], 0);
    check_eq("mr_ex0", obs_ex[0], 0);
    check_eq("mr_cnt", obs_cnt, 0);

    rst_cyc();
    alu(9, 1, 2);
    nop();
    nop();
    use2(9, 0);
    check_eq("byp_stall", {31'd0, obs_stall}, 0);
    nop();
    check_eq("byp_ex0", obs_ex[0], BYP_SEL);

    rst_cyc();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 99) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
